// File: rtl/param_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : param_fifo
//  Purpose  : Parametrised single-clock FIFO with optional first-word-fall-
//             through, occupancy count, almost-full/empty thresholds, flush
//             and clearable sticky overflow/underflow flags.
//  Revision : 1.0  initial release
// ============================================================================
module param_fifo #(
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 16,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    input  logic                       flush,
    input  logic                       clr_err,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam logic [c_ADDR_W:0] c_AFULL  = (c_ADDR_W + 1)'(AFULL_TH);
    localparam logic [c_ADDR_W:0] c_AEMPTY = (c_ADDR_W + 1)'(AEMPTY_TH);

    // Elaboration-time parameter legality checks
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("param_fifo: DEPTH must be a power of two >= 2");
    end
    if (DATA_W < 1) begin : g_chk_width
        $error("param_fifo: DATA_W must be >= 1");
    end
    if ((AFULL_TH < 1) || (AFULL_TH > DEPTH)) begin : g_chk_afull
        $error("param_fifo: AFULL_TH out of range 1..DEPTH");
    end
    if ((AEMPTY_TH < 0) || (AEMPTY_TH > DEPTH - 1)) begin : g_chk_aempty
        $error("param_fifo: AEMPTY_TH out of range 0..DEPTH-1");
    end

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [c_ADDR_W:0]   r_wptr;
    logic [c_ADDR_W:0]   r_rptr;
    logic                r_overflow;
    logic                r_underflow;

    logic                w_full;
    logic                w_empty;
    logic                w_we;
    logic                w_re;
    logic [c_ADDR_W:0]   w_count;
    logic [c_ADDR_W-1:0] w_rd_addr;
    logic [c_ADDR_W-1:0] w_wr_addr;

    // Status is decoded purely from the registered pointers
    assign w_full    = (r_wptr[c_ADDR_W] != r_rptr[c_ADDR_W]) &&
                       (r_wptr[c_ADDR_W-1:0] == r_rptr[c_ADDR_W-1:0]);
    assign w_empty   = (r_wptr == r_rptr);
    assign w_count   = r_wptr - r_rptr;
    assign w_rd_addr = r_rptr[c_ADDR_W-1:0];
    assign w_wr_addr = r_wptr[c_ADDR_W-1:0];

    // Flush suppresses both accesses in its cycle
    assign w_we = wr_en & ~w_full  & ~flush;
    assign w_re = rd_en & ~w_empty & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_we) r_wptr <= r_wptr + 1'b1;
            if (w_re) r_rptr <= r_rptr + 1'b1;
        end
    end

    // Sticky error flags: a new error in the clearing cycle takes priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && w_full && !flush)
                r_overflow <= 1'b1;
            else if (clr_err)
                r_overflow <= 1'b0;

            if (rd_en && w_empty && !flush)
                r_underflow <= 1'b1;
            else if (clr_err)
                r_underflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_wr_addr] <= wr_data;
    end

    if (FWFT != 0) begin : g_fwft
        assign rd_data  = w_empty ? '0 : r_mem[w_rd_addr];
        assign rd_valid = ~w_empty;
    end else begin : g_registered
        logic [DATA_W-1:0] r_rd_data;
        logic              r_rd_valid;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rd_data  <= '0;
                r_rd_valid <= 1'b0;
            end else begin
                r_rd_valid <= w_re;
                if (w_re) r_rd_data <= r_mem[w_rd_addr];
            end
        end

        assign rd_data  = r_rd_data;
        assign rd_valid = r_rd_valid;
    end

    assign full         = w_full;
    assign empty        = w_empty;
    assign count        = w_count;
    assign almost_full  = (w_count >= c_AFULL);
    assign almost_empty = (w_count <= c_AEMPTY);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_param_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_param_fifo
//  Purpose  : Directed bench for param_fifo with a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_param_fifo;

    logic        clk = 1'b0;
    logic        rst_n;

    // Registered-read instance
    logic        wr_en, rd_en, flush, clr_err;
    logic [63:0] wr_data, rd_data;
    logic        rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0]  count;

    // First-word-fall-through instance
    logic        f_wr_en, f_rd_en, f_flush, f_clr_err;
    logic [63:0] f_wr_data, f_rd_data;
    logic        f_rd_valid, f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [4:0]  f_count;

    int          n_cmp = 0;
    int          n_err = 0;

    logic [63:0] m_q[$];
    logic        m_ovf, m_unf;
    logic [63:0] exp_rd;

    always #5 clk = ~clk;

    param_fifo #(.DATA_W(64), .DEPTH(16), .FWFT(0), .AFULL_TH(12), .AEMPTY_TH(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .flush(flush), .clr_err(clr_err),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    param_fifo #(.DATA_W(64), .DEPTH(16), .FWFT(1), .AFULL_TH(12), .AEMPTY_TH(2)) u_dut_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid), .flush(f_flush), .clr_err(f_clr_err),
        .full(f_full), .empty(f_empty), .almost_full(f_almost_full),
        .almost_empty(f_almost_empty), .count(f_count), .overflow(f_overflow),
        .underflow(f_underflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock, update the model from the inputs driven this cycle,
    // then check every registered-read output against the model.
    task automatic tick(input string tag);
        int  cnt;
        bit  mw, mr;
        cnt = m_q.size();
        mw  = wr_en && (cnt != 16) && !flush;
        mr  = rd_en && (cnt != 0)  && !flush;
        if (wr_en && (cnt == 16) && !flush) m_ovf = 1'b1;
        else if (clr_err)                   m_ovf = 1'b0;
        if (rd_en && (cnt == 0) && !flush)  m_unf = 1'b1;
        else if (clr_err)                   m_unf = 1'b0;
        @(posedge clk);
        if (mr) exp_rd = m_q.pop_front();
        if (mw) m_q.push_back(wr_data);
        if (flush) m_q.delete();
        cnt = m_q.size();
        #1;
        chk({tag, ".rd_valid"}, 64'(rd_valid), 64'(mr));
        if (mr) chk({tag, ".rd_data"}, rd_data, exp_rd);
        chk({tag, ".count"}, 64'(count), 64'(cnt));
        chk({tag, ".full"}, 64'(full), 64'(cnt == 16));
        chk({tag, ".empty"}, 64'(empty), 64'(cnt == 0));
        chk({tag, ".afull"}, 64'(almost_full), 64'(cnt >= 12));
        chk({tag, ".aempty"}, 64'(almost_empty), 64'(cnt <= 2));
        chk({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
        chk({tag, ".underflow"}, 64'(underflow), 64'(m_unf));
    endtask

    task automatic idle();
        wr_en = 0; rd_en = 0; flush = 0; clr_err = 0;
    endtask

    task automatic push(input logic [63:0] d, input string tag);
        idle(); wr_en = 1; wr_data = d; tick(tag); idle();
    endtask

    task automatic pop(input string tag);
        idle(); rd_en = 1; tick(tag); idle();
    endtask

    initial begin
        rst_n = 0; idle(); wr_data = '0;
        f_wr_en = 0; f_rd_en = 0; f_flush = 0; f_clr_err = 0; f_wr_data = '0;
        m_ovf = 0; m_unf = 0; exp_rd = '0;
        #12;
        chk("rst.count", 64'(count), 64'd0);
        chk("rst.empty", 64'(empty), 64'd1);
        chk("rst.aempty", 64'(almost_empty), 64'd1);
        chk("rst.rd_data", rd_data, 64'd0);
        chk("rst.f_empty", 64'(f_empty), 64'd1);
        @(negedge clk) rst_n = 1;

        // Reset asserted in the middle of a write burst
        for (int i = 0; i < 5; i++) begin
            wr_en = 1; wr_data = 64'(i + 50); rd_en = (i == 3); tick("burst");
        end
        rst_n = 0;
        #1;
        chk("midrst.count", 64'(count), 64'd0);
        chk("midrst.empty", 64'(empty), 64'd1);
        chk("midrst.full", 64'(full), 64'd0);
        chk("midrst.rd_valid", 64'(rd_valid), 64'd0);
        chk("midrst.rd_data", rd_data, 64'd0);
        chk("midrst.aempty", 64'(almost_empty), 64'd1);
        m_q.delete(); m_ovf = 0; m_unf = 0;
        idle();
        @(negedge clk) rst_n = 1;

        // Fill, overflow, drain
        for (int i = 0; i < 16; i++) push(64'(i), "fill");
        push(64'hDEAD, "ovf");
        chk("ovf.flag", 64'(overflow), 64'd1);
        chk("ovf.count", 64'(count), 64'd16);
        for (int i = 0; i < 16; i++) begin
            pop("drain");
            chk("drain.order", rd_data, 64'(i));
        end
        idle(); tick("drain.idle");
        chk("drain.rd_valid_pulse", 64'(rd_valid), 64'd0);
        clr_err = 1; tick("clr"); idle();

        // Pointer wrap
        for (int i = 0; i < 10; i++) push(64'(i + 200), "wrapw");
        for (int i = 0; i < 10; i++) pop("wrapr");
        for (int i = 0; i < 16; i++) push(64'h100 + 64'(i), "wrapfill");
        chk("wrap.full", 64'(full), 64'd1);
        for (int i = 0; i < 16; i++) begin
            pop("wrapdrain");
            chk("wrap.order", rd_data, 64'h100 + 64'(i));
        end

        // Simultaneous read/write at mid, full, empty
        for (int i = 0; i < 5; i++) push(64'(i + 300), "sim5");
        wr_en = 1; rd_en = 1; wr_data = 64'h777; tick("sim.mid"); idle();
        chk("sim.mid.count", 64'(count), 64'd5);
        for (int i = 0; i < 11; i++) push(64'(i + 400), "simfill");
        wr_en = 1; rd_en = 1; wr_data = 64'h888; tick("sim.full"); idle();
        chk("sim.full.count", 64'(count), 64'd15);
        for (int i = 0; i < 15; i++) pop("simdrain");
        wr_en = 1; rd_en = 1; wr_data = 64'h999; tick("sim.empty"); idle();
        chk("sim.empty.count", 64'(count), 64'd1);
        chk("sim.empty.unf", 64'(underflow), 64'd1);
        clr_err = 1; tick("clr_unf"); idle();
        chk("clr.unf", 64'(underflow), 64'd0);
        pop("last");
        chk("last.data", rd_data, 64'h999);
        clr_err = 1; rd_en = 1; tick("clr_vs_set"); idle();
        chk("setwins.unf", 64'(underflow), 64'd1);

        // Flush with overflow pending and both requests high
        for (int i = 0; i < 17; i++) push(64'(i + 500), "flfill");
        for (int i = 0; i < 9; i++) pop("flpop");
        chk("fl.pre.count", 64'(count), 64'd7);
        flush = 1; wr_en = 1; rd_en = 1; wr_data = 64'hBAD; tick("flush"); idle();
        chk("fl.count", 64'(count), 64'd0);
        chk("fl.empty", 64'(empty), 64'd1);
        chk("fl.ovf", 64'(overflow), 64'd1);
        push(64'h55, "postfl");
        pop("postfl.rd");
        chk("postfl.data", rd_data, 64'h55);

        // First-word-fall-through
        @(negedge clk);
        f_wr_en = 1; f_wr_data = 64'hA5;
        @(posedge clk); #1; f_wr_en = 0;
        chk("fwft.empty", 64'(f_empty), 64'd0);
        chk("fwft.rd_valid", 64'(f_rd_valid), 64'd1);
        chk("fwft.head", f_rd_data, 64'hA5);
        f_wr_en = 1; f_wr_data = 64'hB6;
        @(posedge clk); #1; f_wr_en = 0;
        chk("fwft.hold", f_rd_data, 64'hA5);
        chk("fwft.count2", 64'(f_count), 64'd2);
        f_rd_en = 1;
        @(posedge clk); #1; f_rd_en = 0;
        chk("fwft.next", f_rd_data, 64'hB6);
        chk("fwft.count1", 64'(f_count), 64'd1);
        f_rd_en = 1;
        @(posedge clk); #1; f_rd_en = 0;
        chk("fwft.drained", 64'(f_rd_valid), 64'd0);
        chk("fwft.unf", 64'(f_underflow), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
